// File: rtl/padding_stream_arbiter.sv
// Frame-granular round-robin arbiter in front of a shared padding unit.
// One requester streams a full frame in; the grant is held until the padded frame has left the unit.
module padding_stream_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int IMG_WIDTH      = 4,
  parameter int IMG_HEIGHT     = 3,
  parameter int PADDING_WIDTH  = 2,
  parameter int PADDING_HEIGHT = 2,
  parameter int CHANNELS       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         pad_data,
  output logic                          pad_valid,
  input  logic                          pad_ready,
  input  logic                          pad_out_valid,
  input  logic                          pad_out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int IN_BEATS  = IMG_WIDTH * IMG_HEIGHT * CHANNELS;
  localparam int OUT_BEATS = (IMG_WIDTH + 2*PADDING_WIDTH) * (IMG_HEIGHT + 2*PADDING_HEIGHT) * CHANNELS;
  localparam int CNT_W     = $clog2(OUT_BEATS + 1);

  localparam logic [CNT_W-1:0] IN_FULL  = CNT_W'(IN_BEATS);
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BEATS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BEATS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        in_cnt;
  logic [CNT_W-1:0]        out_cnt;
  logic [ID_W-1:0]         rr_ptr;

  logic                    in_open;
  logic                    in_fire;
  logic                    out_fire;
  logic                    last_in;
  logic                    last_out;
  logic                    sel_valid;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    pick_found;
  logic [ID_W-1:0]         pick_id;
  logic [ID_W-1:0]         cand;

  assign sel_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_valid = req_valid[grant_id];

  // Input side is open only while streaming and the frame is not yet complete.
  assign in_open   = (state == STREAM) && (in_cnt < IN_FULL);
  assign pad_valid = in_open && sel_valid;
  assign pad_data  = (state == STREAM) ? sel_data : '0;
  assign in_fire   = pad_valid && pad_ready;
  assign out_fire  = (state != IDLE) && pad_out_valid && pad_out_ready;
  assign last_in   = in_fire && (in_cnt == IN_LAST);
  assign last_out  = out_fire && (out_cnt == OUT_LAST);

  assign frame_done = last_out;
  assign busy       = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (in_open) req_ready[grant_id] = pad_ready;
  end

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      grant_id <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            rr_ptr   <= pick_id;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (in_fire)  in_cnt  <= in_cnt + 1'b1;
          if (out_fire) out_cnt <= out_cnt + 1'b1;
          // Last output wins over last input so a zero-padding frame returns straight to IDLE.
          if (last_out) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= IDLE;
          end else if (last_in) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) out_cnt <= out_cnt + 1'b1;
          if (last_out) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_padding_stream_arbiter.sv
// Directed bench for padding_stream_arbiter: reset, single/alternating frames, drain blocking,
// random stalls, mid-frame reset, and a zero-padding instance.
module tb_padding_stream_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      pad_data;
  logic               pad_valid, pad_ready, pad_out_valid, pad_out_ready;
  logic [0:0]         grant_id;
  logic               busy, frame_done;

  logic               rst0;
  logic [NR*DW-1:0]   req_data0;
  logic [NR-1:0]      req_valid0;
  logic [NR-1:0]      req_ready0;
  logic [DW-1:0]      pad_data0;
  logic               pad_valid0, pad_ready0, pad_out_valid0, pad_out_ready0;
  logic [0:0]         grant_id0;
  logic               busy0, frame_done0;

  padding_stream_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .IMG_WIDTH(4), .IMG_HEIGHT(3),
    .PADDING_WIDTH(2), .PADDING_HEIGHT(2), .CHANNELS(2)
  ) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .pad_data(pad_data), .pad_valid(pad_valid), .pad_ready(pad_ready),
    .pad_out_valid(pad_out_valid), .pad_out_ready(pad_out_ready),
    .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
  );

  padding_stream_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .IMG_WIDTH(4), .IMG_HEIGHT(3),
    .PADDING_WIDTH(0), .PADDING_HEIGHT(0), .CHANNELS(2)
  ) dut0 (
    .clk(clk), .rst(rst0), .req_data(req_data0), .req_valid(req_valid0), .req_ready(req_ready0),
    .pad_data(pad_data0), .pad_valid(pad_valid0), .pad_ready(pad_ready0),
    .pad_out_valid(pad_out_valid0), .pad_out_ready(pad_out_ready0),
    .grant_id(grant_id0), .busy(busy0), .frame_done(frame_done0)
  );

  int n_cmp = 0;
  int n_err = 0;

  int  sent[NR];
  int  quota[NR];
  bit  want[NR];
  bit  stall_en;

  int  fr_in, fr_out, fr_owner, s_fr_in, r1_ready_cnt;
  bit  fd_pend;
  int  q_owner[$];
  int  q_in[$];
  int  q_out[$];

  logic          s_busy, s_fd;
  logic [NR-1:0] s_rr, s_hs;
  logic [0:0]    s_grant;

  function automatic logic [DW-1:0] mkdata(input int r, input int n);
    return DW'(((r + 1) << 24) | (n & 32'h00FF_FFFF));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      req_valid[r] = want[r] && (sent[r] < quota[r]) && !(stall_en && ($urandom_range(3) == 0));
      req_data[r*DW +: DW] = mkdata(r, sent[r]);
    end
    pad_ready     = stall_en ? 1'($urandom_range(1)) : 1'b1;
    pad_out_ready = stall_en ? 1'($urandom_range(1)) : 1'b1;
    pad_out_valid = 1'b1;
  endtask

  // One clock: sample and account at negedge, then advance requester state and drive after posedge.
  task automatic tick();
    int r;
    @(negedge clk);
    s_busy  = busy;
    s_rr    = req_ready;
    s_fd    = frame_done;
    s_grant = grant_id;
    s_hs    = req_valid & req_ready;
    if (rst) begin
      fr_in   = 0;
      fr_out  = 0;
      fd_pend = 1'b0;
      s_hs    = '0;
    end else begin
      if (fd_pend) begin
        chk("idle_after_done", busy, 0);
        fd_pend = 1'b0;
      end
      chk("hs_match", pad_valid && pad_ready, |s_hs);
      if (req_ready[1]) r1_ready_cnt++;
      if (pad_valid && pad_ready) begin
        r = s_hs[1] ? 1 : 0;
        chk("data", pad_data, mkdata(r, sent[r]));
        if (fr_in == 0) fr_owner = r;
        else chk("no_interleave", r, fr_owner);
        fr_in++;
      end
      if (busy && pad_out_valid && pad_out_ready) fr_out++;
      if (frame_done) begin
        q_owner.push_back(fr_owner);
        q_in.push_back(fr_in);
        q_out.push_back(fr_out);
        fr_in   = 0;
        fr_out  = 0;
        fd_pend = 1'b1;
      end
    end
    s_fr_in = fr_in;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) if (s_hs[k]) sent[k]++;
    drive();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    target = q_owner.size() + n;
    for (int i = 0; i < budget && q_owner.size() < target; i++) tick();
    chk("frame_timeout", q_owner.size() >= target, 1);
  endtask

  task automatic expect_frame(input int idx, input int owner);
    chk("frame_owner", q_owner[idx], owner);
    chk("frame_in_beats", q_in[idx], 24);
    chk("frame_out_beats", q_out[idx], 112);
  endtask

  task automatic clear_q();
    q_owner.delete();
    q_in.delete();
    q_out.delete();
  endtask

  initial begin
    int cnt[NR];
    int in0, out0;
    bit done0;

    rst = 1'b1;
    stall_en = 1'b0;
    fr_in = 0; fr_out = 0; fr_owner = 0; s_fr_in = 0; fd_pend = 1'b0; r1_ready_cnt = 0;
    for (int r = 0; r < NR; r++) begin
      sent[r] = 0; quota[r] = 0; want[r] = 1'b0; cnt[r] = 0;
    end
    rst0 = 1'b1; req_data0 = '0; req_valid0 = '0;
    pad_ready0 = 1'b1; pad_out_valid0 = 1'b1; pad_out_ready0 = 1'b1;

    // Reset values with both requesters asserting
    req_valid = 2'b11;
    req_data = {32'hA5A5_0001, 32'h5A5A_0002};
    pad_ready = 1'b1; pad_out_valid = 1'b1; pad_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_pad_valid", pad_valid, 0);
    chk("reset_pad_data", pad_data, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_grant_id", grant_id, 0);

    // Single frame from req0
    @(posedge clk);
    #1;
    rst = 1'b0;
    want[0] = 1'b1;
    quota[0] = 24;
    drive();
    wait_frames(1, 300);
    tick();
    expect_frame(0, 0);
    chk("s1_r1_never_ready", r1_ready_cnt, 0);
    clear_q();

    // Both valid from reset: alternating grants
    rst = 1'b1;
    want[0] = 1'b1; want[1] = 1'b1;
    quota[0] = sent[0] + 48; quota[1] = sent[1] + 48;
    drive();
    tick();
    tick();
    rst = 1'b0;
    wait_frames(4, 1000);
    tick();
    expect_frame(0, 0);
    expect_frame(1, 1);
    expect_frame(2, 0);
    expect_frame(3, 1);
    clear_q();

    // req1 arrives while req0 drains
    want[1] = 1'b0;
    quota[0] = sent[0] + 24;
    drive();
    s_fr_in = 0;
    for (int i = 0; i < 200 && s_fr_in < 24; i++) tick();
    chk("s3_inputs_done", s_fr_in, 24);
    want[1] = 1'b1;
    quota[1] = sent[1] + 24;
    drive();
    s_fd = 1'b0;
    for (int i = 0; i < 200 && !s_fd; i++) begin
      tick();
      chk("s3_r1_blocked", s_rr[1], 0);
    end
    chk("s3_done_seen", s_fd, 1);
    tick();
    chk("s3_idle_gap", s_busy, 0);
    tick();
    chk("s3_busy", s_busy, 1);
    chk("s3_grant", s_grant, 1);
    wait_frames(1, 300);
    tick();
    expect_frame(0, 0);
    expect_frame(1, 1);
    clear_q();

    // Random stalls on requesters, pad input and pad output
    stall_en = 1'b1;
    want[0] = 1'b1; want[1] = 1'b1;
    quota[0] = sent[0] + 48; quota[1] = sent[1] + 48;
    drive();
    wait_frames(4, 3000);
    stall_en = 1'b0;
    drive();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("s4_in_beats", q_in[i], 24);
      chk("s4_out_beats", q_out[i], 112);
      cnt[q_owner[i] & 1]++;
    end
    chk("s4_frames_req0", cnt[0], 2);
    chk("s4_frames_req1", cnt[1], 2);
    chk("s4_all_sent0", sent[0], quota[0]);
    chk("s4_all_sent1", sent[1], quota[1]);
    clear_q();

    // Reset after 10 input beats of req0
    want[1] = 1'b0;
    want[0] = 1'b1;
    quota[0] = sent[0] + 24;
    drive();
    s_fr_in = 0;
    for (int i = 0; i < 100 && s_fr_in < 10; i++) tick();
    chk("s5_ten_beats", s_fr_in, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    want[1] = 1'b1;
    quota[0] = sent[0] + 24; quota[1] = sent[1] + 24;
    drive();
    tick();
    chk("s5_busy_after_rst", s_busy, 0);
    chk("s5_ready_after_rst", s_rr, 0);
    tick();
    chk("s5_busy", s_busy, 1);
    chk("s5_grant_req0", s_grant, 0);
    wait_frames(2, 600);
    tick();
    expect_frame(0, 0);
    expect_frame(1, 1);
    clear_q();

    // Zero padding: last input and last output coincide
    want[0] = 1'b0; want[1] = 1'b0;
    drive();
    rst0 = 1'b0;
    req_valid0 = 2'b01;
    in0 = 0; out0 = 0; done0 = 1'b0;
    for (int i = 0; i < 100 && !done0; i++) begin
      @(negedge clk);
      if (pad_valid0 && pad_ready0) begin
        chk("z_data", pad_data0, in0);
        in0++;
      end
      if (busy0 && pad_out_valid0 && pad_out_ready0) out0++;
      if (frame_done0) begin
        done0 = 1'b1;
        chk("z_direct_from_stream", pad_valid0, 1);
        chk("z_in_beats", in0, 24);
        chk("z_out_beats", out0, 24);
      end
      @(posedge clk);
      #1;
      req_data0[DW-1:0] = DW'(in0);
    end
    chk("z_done_seen", done0, 1);
    req_valid0 = '0;
    @(negedge clk);
    chk("z_idle_after_done", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
